// File: rtl/fp16_acc_feeder.sv
// Purpose: buffers FP16 words and streams them as fixed-length vectors to an
//          AXI-Stream FP accumulator, then latches the accumulator's final sum.
// Latency: word accepted into an empty FIFO at edge k -> STREAM at k+1, tvalid at k+2.
// Backpressure: in_ready drops when the FIFO is full. The accumulator is never stalled:
//               an empty FIFO mid-vector inserts a tvalid=0 bubble.
// Ports:
//   aclk/aresetn          clock, async active-low reset
//   in_valid/in_data      upstream FP16 words, accepted when in_ready is high
//   vec_len               elements per vector, sampled on IDLE->STREAM
//   m_axis_a_t*           registered element stream to the accumulator
//   s_res_t*              accumulator result stream, used only while waiting
//   result_data/valid     last completed sum; valid pulses for one cycle
//   busy                  high while streaming or waiting for a result
module fp16_acc_feeder #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  input  logic [LEN_W-1:0] vec_len,
  output logic             m_axis_a_tvalid,
  output logic [15:0]      m_axis_a_tdata,
  output logic             m_axis_a_tlast,
  input  logic             s_res_tvalid,
  input  logic [15:0]      s_res_tdata,
  input  logic             s_res_tlast,
  output logic [15:0]      result_data,
  output logic             result_valid,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      occ_q;
  logic             push, pop;

  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             tvalid_q, tvalid_d;
  logic [15:0]      tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [15:0]      res_q, res_d;
  logic             res_vld_q, res_vld_d;
  logic             last_elem;

  // Gated by reset so upstream sees not-ready while the block is held in reset.
  assign in_ready = aresetn && (occ_q < FULL);
  assign push     = in_valid && in_ready;
  assign last_elem = (cnt_q == (len_q - LEN_W'(1)));

  // Storage array has no reset; pointers and occupancy define what is valid.
  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      res_q     <= res_d;
      res_vld_q <= res_vld_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    tdata_d   = tdata_q;   // data holds across bubbles and idle cycles
    res_d     = res_q;
    res_vld_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A zero length never starts a vector, so queued words stay put.
        if (occ_q != '0 && vec_len != '0) begin
          state_d = ST_STREAM;
          len_d   = vec_len;
          cnt_d   = '0;
        end
      end
      ST_STREAM: begin
        if (occ_q != '0) begin
          pop      = 1'b1;
          tvalid_d = 1'b1;
          tdata_d  = mem[rd_ptr_q];
          tlast_d  = last_elem;
          cnt_d    = cnt_q + LEN_W'(1);
          if (last_elem) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Only the final beat of the result stream carries the completed sum.
        if (s_res_tvalid && s_res_tlast) begin
          res_d     = s_res_tdata;
          res_vld_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_axis_a_tvalid = tvalid_q;
  assign m_axis_a_tdata  = tdata_q;
  assign m_axis_a_tlast  = tlast_q;
  assign result_data     = res_q;
  assign result_valid    = res_vld_q;
  assign busy            = (state_q != ST_IDLE);

endmodule
